// File: rtl/arbiter_8_rr_v.sv
// 8-way arbiter for a single shared resource.
// Fixed-priority (bit 7 highest) or round-robin selection. Each grant is
// registered and held until the owner drops its request, signals done, or
// exceeds the hold limit. Every release is followed by one dead cycle
// before the next grant.
//
// state | meaning
// IDLE  | no owner, waiting for any request
// GRANT | one owner holds the resource, hold counter running
// GAP   | single dead cycle after a release, re-arbitrates at its end

module arbiter_8_rr_v #(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 5
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_mode,
   input  logic [7:0] i_req,
   input  logic       i_done,
   output logic [7:0] o_gnt,
   output logic [2:0] o_gnt_id,
   output logic       o_busy,
   output logic       o_timeout
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam bit               TMO_EN    = (MAX_HOLD != 0);
   localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

   state_t           state;
   logic [CNT_W-1:0] hold_cnt;
   logic [2:0]       last;

   logic [2:0]       win_id;
   logic [2:0]       rr_idx;
   logic             win_any;
   logic             rel_req;
   logic             rel_done;
   logic             rel_hold;
   logic             release_now;

   // Winner selection from the live request vector; only consumed when arbitrating.
   // Later loop iterations overwrite earlier ones, so the last hit is the winner.
   always_comb begin
      win_id  = 3'd0;
      rr_idx  = 3'd0;
      win_any = |i_req;
      if (!i_mode) begin
         for (int i = 0; i < 8; i++) begin
            if (i_req[i]) begin
               win_id = 3'(i);
            end
         end
      end else begin
         // Offset 1 (just below last) is visited last and so has top priority;
         // offset 8 wraps back to last itself, which ranks lowest.
         for (int k = 8; k >= 1; k--) begin
            rr_idx = last - 3'(k);
            if (i_req[rr_idx]) begin
               win_id = rr_idx;
            end
         end
      end
   end

   // Release causes for the current owner.
   always_comb begin
      rel_req     = ~i_req[o_gnt_id];
      rel_done    = i_done;
      rel_hold    = TMO_EN && (hold_cnt == HOLD_LAST);
      release_now = rel_req | rel_done | rel_hold;
   end

   // Arbiter state machine with registered grant outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state     <= IDLE;
         hold_cnt  <= '0;
         last      <= 3'd0;
         o_gnt     <= 8'd0;
         o_gnt_id  <= 3'd0;
         o_busy    <= 1'b0;
         o_timeout <= 1'b0;
      end else begin
         o_timeout <= 1'b0;
         case (state)
            IDLE, GAP: begin
               if (win_any) begin
                  state    <= GRANT;
                  o_gnt    <= 8'd1 << win_id;
                  o_gnt_id <= win_id;
                  o_busy   <= 1'b1;
                  hold_cnt <= '0;
               end else begin
                  state <= IDLE;
               end
            end
            GRANT: begin
               if (release_now) begin
                  state     <= GAP;
                  o_gnt     <= 8'd0;
                  o_busy    <= 1'b0;
                  last      <= o_gnt_id;
                  // Only a pure hold-limit release is reported as a timeout.
                  o_timeout <= rel_hold & ~rel_req & ~rel_done;
               end else if (hold_cnt != '1) begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               o_gnt  <= 8'd0;
               o_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_arbiter_8_rr_v.sv
// Scoreboard bench for arbiter_8_rr_v: directed stimulus pushes the expected
// grant records; a negedge monitor measures each grant and pops/compares.

module tb_arbiter_8_rr_v;

   logic       clk;
   logic       rst;
   logic       mode;
   logic [7:0] req;
   logic       done;
   logic [7:0] o_gnt;
   logic [2:0] o_gnt_id;
   logic       o_busy;
   logic       o_timeout;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] gnt;
      logic [2:0] id;
      int         len;
      logic       tmo;
      int         gap;   // 0 = not checked
   } exp_t;

   exp_t exp_q[$];

   arbiter_8_rr_v #(.MAX_HOLD(16), .CNT_W(5)) dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_mode   (mode),
      .i_req    (req),
      .i_done   (done),
      .o_gnt    (o_gnt),
      .o_gnt_id (o_gnt_id),
      .o_busy   (o_busy),
      .o_timeout(o_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] g, input logic [2:0] id, input int len,
                       input logic tmo, input int gap);
      exp_t e;
      e.gnt = g; e.id = id; e.len = len; e.tmo = tmo; e.gap = gap;
      exp_q.push_back(e);
   endtask

   // Monitor: tracks grant windows and checks them against the scoreboard.
   logic       in_grant = 1'b0;
   logic [7:0] cur_gnt;
   logic [2:0] cur_id;
   int         cur_len;
   int         cur_gap;
   int         gap_cnt = 0;

   always @(negedge clk) begin
      if (rst) begin
         in_grant = 1'b0;
         gap_cnt  = 0;
      end else begin
         cmp("inv_onehot", int'($onehot0(o_gnt)), 1);
         cmp("inv_busy", int'(o_busy), int'(o_gnt != 8'd0));
         if (o_gnt != 8'd0) begin
            cmp("inv_id_match", int'(o_gnt), int'(8'd1 << o_gnt_id));
            if (o_timeout) cmp("timeout_during_grant", 1, 0);
            if (!in_grant) begin
               in_grant = 1'b1;
               cur_gnt  = o_gnt;
               cur_id   = o_gnt_id;
               cur_len  = 1;
               cur_gap  = gap_cnt;
            end else begin
               cur_len++;
               if (o_gnt != cur_gnt) cmp("owner_changed", int'(o_gnt), int'(cur_gnt));
            end
         end else if (in_grant) begin
            in_grant = 1'b0;
            gap_cnt  = 1;
            if (exp_q.size() == 0) begin
               cmp("unexpected_grant", int'(cur_gnt), 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               cmp("gnt", int'(cur_gnt), int'(e.gnt));
               cmp("gnt_id", int'(cur_id), int'(e.id));
               cmp("grant_len", cur_len, e.len);
               cmp("timeout", int'(o_timeout), int'(e.tmo));
               if (e.gap != 0) cmp("gap_len", cur_gap, e.gap);
            end
         end else begin
            if (o_timeout) cmp("stray_timeout", 1, 0);
            if (gap_cnt < 1000) gap_cnt++;
         end
      end
   end

   initial begin
      int ids[9];
      rst  = 1'b1;
      mode = 1'b0;
      req  = 8'h00;
      done = 1'b0;
      #1;
      cmp("rst_gnt", int'(o_gnt), 0);
      cmp("rst_id", int'(o_gnt_id), 0);
      cmp("rst_busy", int'(o_busy), 0);
      cmp("rst_timeout", int'(o_timeout), 0);
      tick(2);
      rst = 1'b0;
      tick(2);

      // Reset in the middle of a grant, then resume from IDLE.
      req = 8'h10;
      tick(4);
      cmp("pre_rst_gnt", int'(o_gnt), 8'h10);
      rst = 1'b1;
      #1;
      cmp("midrst_gnt", int'(o_gnt), 0);
      cmp("midrst_busy", int'(o_busy), 0);
      cmp("midrst_id", int'(o_gnt_id), 0);
      tick(1);
      rst = 1'b0;
      push(8'h10, 3'd4, 3, 1'b0, 0);
      tick(3);
      req = 8'h00;
      tick(3);

      // Fixed priority: 0x85 -> 7, drop bit 7 -> gap -> 2.
      mode = 1'b0;
      req  = 8'h85;
      push(8'h80, 3'd7, 1, 1'b0, 0);
      push(8'h04, 3'd2, 3, 1'b0, 1);
      tick(1);
      req = 8'h05;
      tick(4);
      req = 8'h00;
      tick(3);
      cmp("hold_last_id", int'(o_gnt_id), 2);

      // Fresh reset so the round-robin pointer starts from 0.
      rst = 1'b1;
      #1;
      cmp("rst2_id", int'(o_gnt_id), 0);
      tick(1);
      rst = 1'b0;
      tick(1);

      // Round-robin, all requesting, done one cycle into each grant.
      mode = 1'b1;
      ids  = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
      for (int i = 0; i < 9; i++) begin
         push(8'(1 << ids[i]), 3'(ids[i]), 1, 1'b0, (i == 0) ? 0 : 1);
      end
      req = 8'hFF;
      for (int i = 0; i < 9; i++) begin
         tick(1);
         done = 1'b1;
         tick(1);
         done = 1'b0;
      end
      req = 8'h00;
      tick(3);

      // Hold-limit timeout, re-grant, then done + drop exactly at the limit.
      req = 8'h10;
      push(8'h10, 3'd4, 16, 1'b1, 0);
      push(8'h10, 3'd4, 16, 1'b0, 1);
      tick(33);
      done = 1'b1;
      req  = 8'h00;
      tick(1);
      done = 1'b0;
      tick(3);

      // Idle with done toggling: nothing granted, last owner id retained.
      for (int i = 0; i < 50; i++) begin
         done = ~done;
         tick(1);
         if (i % 10 == 9) begin
            cmp("idle_gnt", int'(o_gnt), 0);
            cmp("idle_busy_tmo", int'({o_busy, o_timeout}), 0);
            cmp("idle_id", int'(o_gnt_id), 4);
         end
      end
      done = 1'b0;

      // Mode flip mid-grant leaves the RR-chosen owner in place.
      mode = 1'b1;
      req  = 8'h22;
      push(8'h02, 3'd1, 4, 1'b0, 0);
      push(8'h20, 3'd5, 2, 1'b0, 1);
      tick(2);
      mode = 1'b0;
      tick(2);
      done = 1'b1;
      tick(1);
      done = 1'b0;
      tick(2);
      req = 8'h00;
      tick(3);

      for (int i = 0; i < 50 && (exp_q.size() != 0 || in_grant); i++) tick(1);
      if (exp_q.size() != 0) cmp("scoreboard_drain", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
